// File: rtl/fp2int_bfloat16.sv
// bfloat16 -> signed integer of runtime width b, round-to-nearest-even with saturation, 3-stage valid/ready pipeline.
// Optional FP2INT_SAT_CNT_EN adds a saturating count of clipped results (sat_count, sat_count_clr).
module fp2int_bfloat16 #(
  parameter int unsigned MAX_BITWIDTH_QUANTIZED_DATA = 16,
  parameter int unsigned BITS_EXPONENT               = 8,
  parameter int unsigned BITS_MANTISSA               = 7,
  parameter int unsigned BITS_FLOAT                  = 1 + BITS_EXPONENT + BITS_MANTISSA
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0]   bitwidth_d,
  input  logic [BITS_FLOAT-1:0]                          fp_d,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0]         quantized_d,
  output logic                                           sat_flag,
  output logic                                           nan_flag
`ifdef FP2INT_SAT_CNT_EN
  ,
  input  logic                                           sat_count_clr,
  output logic [15:0]                                    sat_count
`endif
);

  localparam int unsigned MAX  = MAX_BITWIDTH_QUANTIZED_DATA;
  localparam int unsigned BW   = $clog2(MAX) + 1;
  localparam int unsigned EW   = BITS_EXPONENT + 2;
  localparam int unsigned SW   = BITS_MANTISSA + 1;
  localparam int unsigned FW   = MAX + SW;
  localparam int unsigned BIAS = (1 << (BITS_EXPONENT - 1)) - 1;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_NAN  = 2'd2;
  localparam logic [1:0] CLS_SAT  = 2'd3;

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Stage 1: unpack, classify, clamp width
  logic [BITS_EXPONENT-1:0] exp_in;
  logic [BITS_MANTISSA-1:0] mant_in;
  logic [BW-1:0]            b_in;
  logic [1:0]               cls_in;
  logic signed [EW-1:0]     e_in;

  always_comb begin
    exp_in  = fp_d[BITS_FLOAT-2 -: BITS_EXPONENT];
    mant_in = fp_d[BITS_MANTISSA-1:0];
    b_in    = bitwidth_d;
    cls_in  = CLS_NORM;
    e_in    = $signed(EW'(exp_in)) - $signed(EW'(BIAS));
    if (bitwidth_d < BW'(2))        b_in = BW'(2);
    else if (bitwidth_d > BW'(MAX)) b_in = BW'(MAX);
    if (exp_in == '0)               cls_in = CLS_ZERO;
    else if (exp_in == '1)          cls_in = (mant_in != '0) ? CLS_NAN : CLS_SAT;
  end

  logic                 s1_valid, s1_sign;
  logic [1:0]           s1_cls;
  logic [SW-1:0]        s1_sig;
  logic signed [EW-1:0] s1_e;
  logic [BW-1:0]        s1_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_sig   <= '0;
      s1_e     <= '0;
      s1_b     <= BW'(2);
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= fp_d[BITS_FLOAT-1];
      s1_cls   <= cls_in;
      s1_sig   <= {1'b1, mant_in};
      s1_e     <= e_in;
      s1_b     <= b_in;
    end
  end

  // Stage 2: align; value * 2^SW = sig << (e+1), so the low SW bits hold guard and sticky
  logic [EW-1:0]  sh;
  logic [FW-1:0]  full;
  logic [MAX-1:0] mag_al;
  logic           guard_al, sticky_al;
  logic [1:0]     cls_al;

  always_comb begin
    sh        = s1_e + EW'(1);
    full      = FW'(s1_sig) << sh;
    mag_al    = full[FW-1:SW];
    guard_al  = full[SW-1];
    sticky_al = |full[SW-2:0];
    cls_al    = s1_cls;
    if (sh[EW-1]) begin
      mag_al    = '0;
      guard_al  = 1'b0;
      sticky_al = 1'b1;
    end
    if (s1_cls == CLS_NORM && $signed(s1_e) >= $signed(EW'(s1_b))) cls_al = CLS_SAT;
  end

  logic           s2_valid, s2_sign, s2_guard, s2_sticky;
  logic [1:0]     s2_cls;
  logic [MAX-1:0] s2_mag;
  logic [BW-1:0]  s2_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_cls    <= CLS_ZERO;
      s2_mag    <= '0;
      s2_b      <= BW'(2);
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_guard  <= guard_al;
      s2_sticky <= sticky_al;
      s2_cls    <= cls_al;
      s2_mag    <= mag_al;
      s2_b      <= s1_b;
    end
  end

  // Stage 3: round, saturate, sign, mask
  logic           inc;
  logic [MAX:0]   rnd;
  logic [MAX-1:0] half, limit, val, twos, mask, q_nxt;
  logic           clip, sat_nxt, nan_nxt;

  always_comb begin
    inc     = s2_guard & (s2_sticky | s2_mag[0]);
    rnd     = (MAX+1)'(s2_mag) + (MAX+1)'(inc);
    half    = MAX'(1) << (s2_b - BW'(1));
    limit   = s2_sign ? half : half - MAX'(1);
    mask    = {MAX{1'b1}} >> (BW'(MAX) - s2_b);
    clip    = 1'b0;
    val     = '0;
    nan_nxt = 1'b0;
    case (s2_cls)
      CLS_NORM: begin
        clip = rnd > (MAX+1)'(limit);
        val  = clip ? limit : rnd[MAX-1:0];
      end
      CLS_SAT: begin
        clip = 1'b1;
        val  = limit;
      end
      CLS_NAN:  nan_nxt = 1'b1;
      default:  val = '0;
    endcase
    twos    = s2_sign ? (~val + MAX'(1)) : val;
    q_nxt   = twos & mask;
    sat_nxt = clip & s2_valid;
    nan_nxt = nan_nxt & s2_valid;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      quantized_d <= '0;
      sat_flag    <= 1'b0;
      nan_flag    <= 1'b0;
    end else if (adv) begin
      out_valid   <= s2_valid;
      quantized_d <= q_nxt;
      sat_flag    <= sat_nxt;
      nan_flag    <= nan_nxt;
    end
  end

`ifdef FP2INT_SAT_CNT_EN
  // Clipped-result counter; clear beats increment, sticks at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                   sat_count <= '0;
    else if (sat_count_clr)                                      sat_count <= '0;
    else if (out_valid & out_ready & sat_flag & ~(&sat_count))   sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fp2int_bfloat16.sv
// Self-checking bench for fp2int_bfloat16: real-arithmetic reference model, directed literals, random stream with backpressure.
module tb_fp2int_bfloat16;

  typedef struct packed {logic sat; logic nan; logic [15:0] q;} res_t;
  typedef struct {res_t e; bit hl; res_t lit; int cyc; bit lat;} ent_t;

  logic        clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, sat_flag, nan_flag;
  logic [4:0]  bitwidth_d = 5'd0;
  logic [15:0] fp_d = 16'h0, quantized_d;
`ifdef FP2INT_SAT_CNT_EN
  logic        sat_count_clr = 1'b0;
  logic [15:0] sat_count;
  logic [15:0] m_cnt = 16'h0;
`endif

  fp2int_bfloat16 dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .bitwidth_d(bitwidth_d), .fp_d(fp_d), .out_valid(out_valid), .out_ready(out_ready),
    .quantized_d(quantized_d), .sat_flag(sat_flag), .nan_flag(nan_flag)
`ifdef FP2INT_SAT_CNT_EN
    , .sat_count_clr(sat_count_clr), .sat_count(sat_count)
`endif
  );

  ent_t q_exp[$];
  ent_t acc_e, out_e;
  int   total = 0, bad = 0, cyc = 0;
  bit   cur_hl = 1'b0, lat_mode = 1'b0, rnd_mode = 1'b0, xsat;
  res_t cur_lit = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rnd_mode) begin #1; out_ready = ($urandom_range(0, 3) != 0); end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  // Value = (-1)^s * (128+mant) * 2^(exp-134), rounded half-to-even, clipped to [-2^(b-1), 2^(b-1)-1]
  function automatic res_t model(input logic [15:0] f, input logic [4:0] bw);
    res_t r;
    int   bb, ex;
    real  mag, fl, v, lim;
    r  = '0;
    bb = (bw < 5'd2) ? 2 : (bw > 5'd16) ? 16 : int'(bw);
    ex = int'(f[14:7]);
    lim = 1.0;
    for (int i = 1; i < bb; i++) lim = lim * 2.0;
    if (ex == 255 && f[6:0] != 7'd0) begin r.nan = 1'b1; return r; end
    if (ex == 0) return r;
    if (ex == 255) mag = 1.0e30;
    else begin
      mag = real'(128 + int'(f[6:0]));
      if (ex > 134) for (int i = 134; i < ex; i++) mag = mag * 2.0;
      else          for (int i = ex; i < 134; i++) mag = mag / 2.0;
      if (mag < 1.0e6) begin
        fl = $floor(mag);
        if (mag - fl > 0.5 || (mag - fl == 0.5 && ($rtoi(fl) % 2) == 1)) mag = fl + 1.0;
        else mag = fl;
      end
    end
    v = f[15] ? -mag : mag;
    if (v > lim - 1.0) begin v = lim - 1.0; r.sat = 1'b1; end
    if (v < -lim)      begin v = -lim;      r.sat = 1'b1; end
    r.q = 16'($rtoi(v)) & 16'((32'd1 << bb) - 1);
    return r;
  endfunction

  function automatic res_t mk(input logic s, input logic n, input logic [15:0] q);
    res_t r;
    r.sat = s; r.nan = n; r.q = q;
    return r;
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [7:0] ex;
    int k = $urandom_range(0, 15);
    if (k == 0)      ex = 8'h00;
    else if (k == 1) ex = 8'hFF;
    else if (k == 2) ex = 8'($urandom_range(1, 254));
    else             ex = 8'(124 + $urandom_range(0, 22));
    return {1'($urandom), ex, 7'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Compare process: handshake relation, accept bookkeeping, output check
  always @(negedge clk) begin
    if (!rstn) begin
`ifdef FP2INT_SAT_CNT_EN
      m_cnt = 16'h0;
`endif
    end else begin
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++;
        $display("FAIL in_ready got=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (in_valid && in_ready) begin
        acc_e.e   = model(fp_d, bitwidth_d);
        acc_e.hl  = cur_hl;
        acc_e.lit = cur_lit;
        acc_e.cyc = cyc;
        acc_e.lat = lat_mode;
        q_exp.push_back(acc_e);
      end
      xsat = 1'b0;
      if (out_valid && out_ready) begin
        total++;
        if (q_exp.size() == 0) begin
          bad++;
          $display("FAIL extra_output q=%h sat=%b nan=%b", quantized_d, sat_flag, nan_flag);
        end else begin
          out_e = q_exp.pop_front();
          xsat  = out_e.e.sat;
          if ({sat_flag, nan_flag, quantized_d} !== out_e.e) begin
            bad++;
            $display("FAIL out_model got q=%h s=%b n=%b want q=%h s=%b n=%b",
                     quantized_d, sat_flag, nan_flag, out_e.e.q, out_e.e.sat, out_e.e.nan);
          end
          if (out_e.hl) begin
            total++;
            if ({sat_flag, nan_flag, quantized_d} !== out_e.lit) begin
              bad++;
              $display("FAIL out_literal got q=%h s=%b n=%b want q=%h s=%b n=%b",
                       quantized_d, sat_flag, nan_flag, out_e.lit.q, out_e.lit.sat, out_e.lit.nan);
            end
          end
          if (out_e.lat) begin
            total++;
            if (cyc - out_e.cyc != 3) begin
              bad++;
              $display("FAIL latency got=%0d want=3", cyc - out_e.cyc);
            end
          end
        end
      end
`ifdef FP2INT_SAT_CNT_EN
      total++;
      if (sat_count !== m_cnt) begin
        bad++;
        $display("FAIL sat_count_model got=%h want=%h", sat_count, m_cnt);
      end
      if (sat_count_clr)              m_cnt = 16'h0;
      else if (xsat && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
  end

  task automatic send(input logic [15:0] f, input logic [4:0] b, input bit hl, input res_t lit);
    int n = 0;
    in_valid = 1'b1; fp_d = f; bitwidth_d = b; cur_hl = hl; cur_lit = lit;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; cur_hl = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    chk("drain_empty", 32'(q_exp.size()), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quantized", 32'(quantized_d), 32'd0);
    chk("rst_flags", {30'd0, sat_flag, nan_flag}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Directed conversions with hand-computed results, no backpressure
    lat_mode = 1'b1;
    send(16'h3FC0, 5'd8,  1, mk(0, 0, 16'h0002));
    send(16'h4020, 5'd8,  1, mk(0, 0, 16'h0002));
    send(16'h3F00, 5'd8,  1, mk(0, 0, 16'h0000));
    send(16'hC2FE, 5'd8,  1, mk(0, 0, 16'h0081));
    send(16'hC300, 5'd8,  1, mk(0, 0, 16'h0080));
    send(16'hC301, 5'd8,  1, mk(1, 0, 16'h0080));
    send(16'h4396, 5'd8,  1, mk(1, 0, 16'h007F));
    send(16'h7F80, 5'd16, 1, mk(1, 0, 16'h7FFF));
    send(16'h7FC0, 5'd16, 1, mk(0, 1, 16'h0000));
    send(16'h8000, 5'd16, 1, mk(0, 0, 16'h0000));
    send(16'h0001, 5'd16, 1, mk(0, 0, 16'h0000));
    send(16'h4000, 5'd1,  1, mk(1, 0, 16'h0001));
    send(16'hBFC0, 5'd0,  1, mk(0, 0, 16'h0002));
    send(16'hC700, 5'd31, 1, mk(0, 0, 16'h8000));
    drain();

    // Back-to-back stream with a 5-cycle consumer stall mid-stream
    lat_mode = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(16'h4040, 5'd8, 1, mk(0, 0, 16'h0003));
    send(16'h4080, 5'd8, 1, mk(0, 0, 16'h0004));
    send(16'hC0A0, 5'd8, 1, mk(0, 0, 16'h00FB));
    send(16'h3FE0, 5'd8, 1, mk(0, 0, 16'h0002));
    send(16'h4110, 5'd8, 1, mk(0, 0, 16'h0009));
    send(16'h42C8, 5'd8, 1, mk(0, 0, 16'h0064));
    drain();
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset with samples in flight
    out_ready = 1'b0;
    send(16'h4396, 5'd8, 0, '0);
    send(16'h7FC0, 5'd8, 0, '0);
    send(16'h3FC0, 5'd8, 0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_sat", 32'(sat_flag), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_flags", {30'd0, sat_flag, nan_flag}, 32'd0);
    chk("async_rst_quantized", 32'(quantized_d), 32'd0);
    q_exp.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send(16'h4040, 5'd8, 1, mk(0, 0, 16'h0003));
    drain();
    lat_mode = 1'b0;

    // Random stream with random gaps, widths and backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) send(rand_fp(), 5'($urandom_range(0, 31)), 0, '0);
      else begin @(posedge clk); #1; end
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

`ifdef FP2INT_SAT_CNT_EN
    sat_count_clr = 1'b1;
    @(posedge clk); #1 sat_count_clr = 1'b0;
    send(16'h4396, 5'd8,  0, '0);
    send(16'h3FC0, 5'd8,  0, '0);
    send(16'h7F80, 5'd16, 0, '0);
    send(16'h4040, 5'd8,  0, '0);
    send(16'hC301, 5'd8,  0, '0);
    drain();
    repeat (2) @(posedge clk);
    #1 chk("sat_count_three", 32'(sat_count), 32'd3);
    out_ready = 1'b0;
    send(16'h7F80, 5'd16, 0, '0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    chk("wait_sat_output", 32'(out_valid), 32'd1);
    sat_count_clr = 1'b1;
    out_ready     = 1'b1;
    @(posedge clk);
    #1 sat_count_clr = 1'b0;
    chk("sat_count_clr_wins", 32'(sat_count), 32'd0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
